// File: rtl/bitscan_encoder_16to4_pkg.sv
// ---------------------------------------------------------------------------
// bitscan_encoder_16to4_pkg
// Shared definitions for the 16-to-4 bit-scan encoder.
//   state_t      : encoder FSM state (IDLE, EMIT)
//   VEC_W        : width of the vector being scanned (16)
//   IDX_W        : width of a bit index within that vector (4)
//   idx_to_mask  : one-hot mask for a given bit index
// ---------------------------------------------------------------------------
package bitscan_encoder_16to4_pkg;

    localparam int VEC_W = 16;
    localparam int IDX_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [VEC_W-1:0] idx_to_mask(input logic [IDX_W-1:0] idx);
        return VEC_W'(1) << idx;
    endfunction

endpackage

// File: rtl/bitscan_encoder_16to4_if.sv
// ---------------------------------------------------------------------------
// bitscan_encoder_16to4_if
// Input and output handshakes of the bit-scan encoder.
//   in_valid/in_ready/inp         : vector capture handshake
//   out_valid/out_ready/out       : one index beat per handshake
//   out_last                      : final index of the captured vector
//   out_zero                      : captured vector was all zeros
// Modports: master = producer/consumer side, slave = encoder side.
// ---------------------------------------------------------------------------
interface bitscan_encoder_16to4_if;
    import bitscan_encoder_16to4_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [VEC_W-1:0] inp;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out;
    logic             out_last;
    logic             out_zero;

    modport master (
        output in_valid, inp, out_ready,
        input  in_ready, out_valid, out, out_last, out_zero
    );

    modport slave (
        input  in_valid, inp, out_ready,
        output in_ready, out_valid, out, out_last, out_zero
    );

endinterface

// File: rtl/bitscan_encoder_16to4_prio_enc.sv
// ---------------------------------------------------------------------------
// prio_enc_16to4
// Combinational priority encoder.
//   vec       : input vector
//   msb_first : 1 = report the highest set bit, 0 = the lowest
//   idx       : index of the selected set bit (0 when vec is empty)
//   none      : vec has no bit set
// ---------------------------------------------------------------------------
module prio_enc_16to4
    import bitscan_encoder_16to4_pkg::*;
(
    input  logic [VEC_W-1:0] vec,
    input  logic             msb_first,
    output logic [IDX_W-1:0] idx,
    output logic             none
);

    // The later assignment in each loop wins, so the scan direction is
    // chosen so that the preferred bit is visited last.
    always_comb begin
        idx  = '0;
        none = ~|vec;
        if (msb_first) begin
            for (int i = 0; i < VEC_W; i++) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = VEC_W - 1; i >= 0; i--) begin
                if (vec[i]) idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bitscan_encoder_16to4.sv
// ---------------------------------------------------------------------------
// bitscan_encoder_16to4
// Captures a 16-bit vector and emits the index of every set bit, one beat
// per out handshake, in MSB-first or LSB-first order. An all-zero vector
// yields a single beat flagged with out_zero.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   en    : block enable; low blocks accepts and stalls the output
//   bus   : handshake interface (slave side)
// Parameter MSB_FIRST: 1 = highest set bit first, 0 = lowest first.
// ---------------------------------------------------------------------------
module bitscan_encoder_16to4
    import bitscan_encoder_16to4_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    bitscan_encoder_16to4_if.slave  bus
);

    state_t           state, state_nxt;
    logic [VEC_W-1:0] mask, mask_nxt;
    logic             zero_flag, zero_nxt;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_none;
    logic             emitting;
    logic             in_ready_w;
    logic             out_valid_w;
    logic             last_w;
    logic             accept;
    logic             beat;

    prio_enc_16to4 u_prio (
        .vec       (mask),
        .msb_first (MSB_FIRST),
        .idx       (sel_idx),
        .none      (sel_none)
    );

    // All outputs are decoded from state, mask and zero flag, so reset
    // clears them as soon as rst_n falls.
    always_comb begin
        emitting    = (state == EMIT);
        in_ready_w  = (state == IDLE) && en;
        out_valid_w = emitting && en;
        // An empty mask only occurs for the all-zero beat, which is also last.
        last_w      = sel_none || ((mask & (mask - VEC_W'(1))) == '0);
        accept      = bus.in_valid && in_ready_w;
        beat        = out_valid_w && bus.out_ready;

        bus.in_ready  = in_ready_w;
        bus.out_valid = out_valid_w;
        bus.out       = emitting ? sel_idx : '0;
        bus.out_last  = emitting && last_w;
        bus.out_zero  = emitting && zero_flag;
    end

    always_comb begin
        state_nxt = state;
        mask_nxt  = mask;
        zero_nxt  = zero_flag;
        case (state)
            IDLE: begin
                if (accept) begin
                    mask_nxt  = bus.inp;
                    zero_nxt  = ~|bus.inp;
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (beat) begin
                    mask_nxt = mask & ~idx_to_mask(sel_idx);
                    if (last_w) begin
                        zero_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask      <= '0;
            zero_flag <= 1'b0;
        end else begin
            mask      <= mask_nxt;
            zero_flag <= zero_nxt;
        end
    end

endmodule

// File: tb/tb_bitscan_encoder_16to4.sv
// ---------------------------------------------------------------------------
// tb_bitscan_encoder_16to4
// Self-checking bench: one MSB-first and one LSB-first encoder instance,
// table of directed vectors plus hand-written multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_bitscan_encoder_16to4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;

    int total = 0;
    int bad = 0;
    int k;
    int cyc;

    typedef struct {
        logic [15:0] inp;
        int          n;
        logic [63:0] seq;
        logic        z;
    } vec_t;

    vec_t tbl[$];

    bitscan_encoder_16to4_if bm ();
    bitscan_encoder_16to4_if bl ();

    bitscan_encoder_16to4 #(.MSB_FIRST(1'b1)) u_msb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bm.slave)
    );

    bitscan_encoder_16to4 #(.MSB_FIRST(1'b0)) u_lsb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bl.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input logic [15:0] v, input int n, input logic [63:0] seq,
                           input logic z, input string tag);
        @(negedge clk);
        bm.in_valid  = 1'b1;
        bm.inp       = v;
        bm.out_ready = 1'b1;
        #1;
        chk({tag, ".rdy"}, 32'(bm.in_ready), 32'd1);
        @(negedge clk);
        bm.in_valid = 1'b0;
        bm.inp      = 16'h0;
        #1;
        for (int b = 0; b < n; b++) begin
            chk({tag, ".vld"},  32'(bm.out_valid), 32'd1);
            chk({tag, ".idx"},  32'(bm.out), 32'(seq[4*b +: 4]));
            chk({tag, ".last"}, 32'(bm.out_last), 32'(b == n - 1));
            chk({tag, ".zero"}, 32'(bm.out_zero), 32'(z));
            @(negedge clk);
            #1;
        end
        chk({tag, ".done_vld"}, 32'(bm.out_valid), 32'd0);
        chk({tag, ".done_rdy"}, 32'(bm.in_ready), 32'd1);
        chk({tag, ".done_out"}, 32'(bm.out), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bm.in_valid = 1'b0; bm.inp = 16'h0; bm.out_ready = 1'b0;
        bl.in_valid = 1'b0; bl.inp = 16'h0; bl.out_ready = 1'b0;

        tbl.push_back('{16'h8421, 4, 64'h05AF, 1'b0});
        for (int i = 0; i < 16; i++) tbl.push_back('{16'(1 << i), 1, 64'(i), 1'b0});
        tbl.push_back('{16'h0000, 1, 64'h0, 1'b1});
        tbl.push_back('{16'h0003, 2, 64'h01, 1'b0});
        tbl.push_back('{16'hA000, 2, 64'hDF, 1'b0});
        tbl.push_back('{16'h8001, 2, 64'h0F, 1'b0});

        // reset state
        #2;
        chk("rst.vld",  32'(bm.out_valid), 32'd0);
        chk("rst.out",  32'(bm.out), 32'd0);
        chk("rst.last", 32'(bm.out_last), 32'd0);
        chk("rst.zero", 32'(bm.out_zero), 32'd0);
        chk("rst.lsb_vld", 32'(bl.out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_vec(tbl[i].inp, tbl[i].n, tbl[i].seq, tbl[i].z, $sformatf("vec%0d", i));
        end

        // inputs ignored while emitting; next vector accepted after an IDLE cycle
        @(negedge clk);
        bm.in_valid = 1'b1; bm.inp = 16'h0003; bm.out_ready = 1'b1;
        @(negedge clk);
        bm.inp = 16'h8000;
        #1;
        chk("emit_ign.rdy0", 32'(bm.in_ready), 32'd0);
        chk("emit_ign.idx0", 32'(bm.out), 32'd1);
        chk("emit_ign.last0", 32'(bm.out_last), 32'd0);
        @(negedge clk); #1;
        chk("emit_ign.rdy1", 32'(bm.in_ready), 32'd0);
        chk("emit_ign.idx1", 32'(bm.out), 32'd0);
        chk("emit_ign.last1", 32'(bm.out_last), 32'd1);
        @(negedge clk); #1;
        chk("emit_ign.idle_rdy", 32'(bm.in_ready), 32'd1);
        chk("emit_ign.idle_vld", 32'(bm.out_valid), 32'd0);
        @(negedge clk);
        bm.in_valid = 1'b0;
        #1;
        chk("emit_ign.next_vld", 32'(bm.out_valid), 32'd1);
        chk("emit_ign.next_idx", 32'(bm.out), 32'd15);
        @(negedge clk); #1;
        chk("emit_ign.end_vld", 32'(bm.out_valid), 32'd0);

        // en low blocks accept; raising en accepts on the next edge
        @(negedge clk);
        en = 1'b0; bm.in_valid = 1'b1; bm.inp = 16'h0010;
        #1;
        chk("en0.rdy", 32'(bm.in_ready), 32'd0);
        @(negedge clk); #1;
        chk("en0.vld", 32'(bm.out_valid), 32'd0);
        chk("en0.rdy2", 32'(bm.in_ready), 32'd0);
        en = 1'b1;
        #1;
        chk("en1.rdy", 32'(bm.in_ready), 32'd1);
        @(negedge clk);
        bm.in_valid = 1'b0;
        #1;
        chk("en1.vld", 32'(bm.out_valid), 32'd1);
        chk("en1.idx", 32'(bm.out), 32'd4);
        @(negedge clk); #1;
        chk("en1.end", 32'(bm.out_valid), 32'd0);

        // reset mid-stream discards remaining indices
        @(negedge clk);
        bm.in_valid = 1'b1; bm.inp = 16'h00F0;
        @(negedge clk);
        bm.in_valid = 1'b0;
        #1;
        chk("rstmid.idx7", 32'(bm.out), 32'd7);
        @(negedge clk); #1;
        chk("rstmid.idx6", 32'(bm.out), 32'd6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid.vld", 32'(bm.out_valid), 32'd0);
        chk("rstmid.out", 32'(bm.out), 32'd0);
        chk("rstmid.last", 32'(bm.out_last), 32'd0);
        chk("rstmid.zero", 32'(bm.out_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rstmid.quiet", 32'(bm.out_valid), 32'd0);
        end
        run_vec(16'h0002, 1, 64'h1, 1'b0, "post_rst");

        // LSB-first, all ones, out_ready toggling, en dropped mid-stream
        @(negedge clk);
        bl.in_valid = 1'b1; bl.inp = 16'hFFFF; bl.out_ready = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 80) begin
            @(negedge clk);
            bl.in_valid  = 1'b0;
            bl.out_ready = (cyc % 2 == 0);
            en           = !(cyc >= 6 && cyc < 9);
            #1;
            if (!en) begin
                chk("ffff.stall_vld", 32'(bl.out_valid), 32'd0);
            end else begin
                chk("ffff.vld",  32'(bl.out_valid), 32'd1);
                chk("ffff.idx",  32'(bl.out), 32'(k));
                chk("ffff.last", 32'(bl.out_last), 32'(k == 15));
                chk("ffff.zero", 32'(bl.out_zero), 32'd0);
                if (bl.out_ready) k++;
            end
            cyc++;
        end
        en = 1'b1;
        chk("ffff.beats", 32'(k), 32'd16);
        @(negedge clk); #1;
        chk("ffff.end_vld", 32'(bl.out_valid), 32'd0);
        chk("ffff.end_rdy", 32'(bl.in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
